// File: rtl/line_rotation_pkg.sv
// Shared definitions for the line rotation scheduler and its descrambler twin:
// LFSR geometry, the Galois step function and the scheduler state encoding.
package line_rotation_pkg;

  localparam int              LFSR_WIDTH    = 16;
  localparam logic [15:0]     LFSR_TAPS     = 16'hB400;
  localparam int              CUT_BITS      = 8;
  localparam int              LINE_IDX_BITS = 10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIELD = 2'd1,
    RUN        = 2'd2
  } sched_state_t;

  // Right-shifting Galois step; the feedback mask is applied when bit 0 falls out.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : {LFSR_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/line_rotation_scheduler_sync_edge_detect.sv
// Registered H/V edge detector shared by scrambler and descrambler schedulers.
// Inputs are registered once, so pulses lag the raw sync flags by one clock.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_h,
  input  logic i_v,
  output logic o_h_rise,
  output logic o_fs,
  output logic o_v
);

  logic r_h_d;
  logic r_prev_h;
  logic r_v_d;
  logic r_prev_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_d    <= 1'b0;
      r_prev_h <= 1'b0;
      r_v_d    <= 1'b0;
      r_prev_v <= 1'b0;
    end else begin
      r_h_d    <= i_h;
      r_prev_h <= r_h_d;
      r_v_d    <= i_v;
      r_prev_v <= r_v_d;
    end
  end

  // Field start is the falling edge of vertical blanking.
  assign o_h_rise = r_h_d & ~r_prev_h;
  assign o_fs     = ~r_v_d & r_prev_v;
  assign o_v      = r_v_d;

endmodule

// File: rtl/line_rotation_scheduler.sv
// Per-line cut scheduler: reseeds a Galois LFSR from the session key at every
// field start and emits one cut position per active line.
module line_rotation_scheduler
  import line_rotation_pkg::*;
#(
  parameter int LIDX_BITS = LINE_IDX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  H,
  input  logic                  V,
  input  logic                  F,
  input  logic                  enable,
  input  logic [LFSR_WIDTH-1:0] key_in,
  input  logic                  key_valid,
  output logic                  key_ready,
  output logic [CUT_BITS-1:0]   cut_position,
  output logic                  cut_valid,
  output logic [LIDX_BITS-1:0]  line_index,
  output logic                  field_start,
  output logic                  running
);

  localparam int HALF = LFSR_WIDTH / 2;

  sched_state_t          r_state;
  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic [LFSR_WIDTH-1:0] r_pend_key;
  logic                  r_pend_full;
  logic [LFSR_WIDTH-1:0] r_active_key;
  logic [CUT_BITS-1:0]   r_cut;
  logic                  r_cut_valid;
  logic [LIDX_BITS-1:0]  r_line_idx;
  logic                  r_field_start;
  logic                  r_running;
  logic                  r_f_d;

  logic                  w_h_rise;
  logic                  w_fs;
  logic                  w_v;
  logic                  w_hs;
  logic [LFSR_WIDTH-1:0] w_sel_key;
  logic [LFSR_WIDTH-1:0] w_seed_raw;
  logic [LFSR_WIDTH-1:0] w_seed;
  logic [LFSR_WIDTH-1:0] w_lfsr_next;

  sync_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .i_h      (H),
    .i_v      (V),
    .o_h_rise (w_h_rise),
    .o_fs     (w_fs),
    .o_v      (w_v)
  );

  assign key_ready = ~r_pend_full;
  assign w_hs      = key_valid & ~r_pend_full;

  // A key arriving on the field-start cycle is used at once; else pending, else last key.
  assign w_sel_key   = w_hs ? key_in : (r_pend_full ? r_pend_key : r_active_key);
  assign w_seed_raw  = r_f_d ? {w_sel_key[HALF-1:0], w_sel_key[LFSR_WIDTH-1:HALF]} : w_sel_key;
  assign w_seed      = (w_seed_raw == '0) ? LFSR_WIDTH'(1) : w_seed_raw;
  assign w_lfsr_next = lfsr_next(r_lfsr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_lfsr        <= '0;
      r_pend_key    <= '0;
      r_pend_full   <= 1'b0;
      r_active_key  <= '0;
      r_cut         <= '0;
      r_cut_valid   <= 1'b0;
      r_line_idx    <= '0;
      r_field_start <= 1'b0;
      r_running     <= 1'b0;
      r_f_d         <= 1'b0;
    end else begin
      r_f_d         <= F;
      r_cut_valid   <= 1'b0;
      r_field_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_pend_key  <= key_in;
            r_pend_full <= 1'b1;
            r_state     <= WAIT_FIELD;
          end
        end
        WAIT_FIELD, RUN: begin
          if (w_fs) begin
            r_active_key  <= w_sel_key;
            r_lfsr        <= w_seed;
            r_pend_full   <= 1'b0;
            r_field_start <= 1'b1;
            r_line_idx    <= '0;
            r_state       <= RUN;
            r_running     <= 1'b1;
          end else begin
            if (w_hs) begin
              r_pend_key  <= key_in;
              r_pend_full <= 1'b1;
            end
            // The LFSR advances even when disabled so the descrambler stays in step.
            if (r_state == RUN && w_h_rise && !w_v) begin
              r_lfsr      <= w_lfsr_next;
              r_cut       <= enable ? w_lfsr_next[CUT_BITS-1:0] : '0;
              r_cut_valid <= 1'b1;
              if (r_line_idx != '1) begin
                r_line_idx <= r_line_idx + LIDX_BITS'(1);
              end
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign cut_position = r_cut;
  assign cut_valid    = r_cut_valid;
  assign line_index   = r_line_idx;
  assign field_start  = r_field_start;
  assign running      = r_running;

endmodule

// File: tb/tb_line_rotation_scheduler.sv
// Directed bench for line_rotation_scheduler: a cycle-level reference model
// built from the sync/key rules, compared every cycle, plus literal pins.
module tb_line_rotation_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        H, V, F, enable, key_valid;
  logic [15:0] key_in;
  logic        key_ready, cut_valid, field_start, running;
  logic [7:0]  cut_position;
  logic [9:0]  line_index;

  always #5 clk = ~clk;

  line_rotation_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .H            (H),
    .V            (V),
    .F            (F),
    .enable       (enable),
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .cut_position (cut_position),
    .cut_valid    (cut_valid),
    .line_index   (line_index),
    .field_start  (field_start),
    .running      (running)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic [15:0] t;
    t = s / 16'd2;
    if (s % 2 == 1) t = t ^ 16'hB400;
    return t;
  endfunction

  int          m_state;       // 0 no key, 1 waiting for field, 2 running
  logic [15:0] m_lfsr, m_pend, m_active, m_key, m_seed;
  bit          m_pfull, m_cv, m_fs_out, m_run, m_valid = 1'b0;
  logic [7:0]  m_cut;
  int          m_idx;
  bit          hh1, hh2, vh1, vh2, fh1;
  bit          m_hr, m_fs, m_hs;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_state = 0; m_lfsr = 0; m_pend = 0; m_active = 0; m_pfull = 0;
      m_cut = 0; m_cv = 0; m_fs_out = 0; m_run = 0; m_idx = 0;
      hh1 = 0; hh2 = 0; vh1 = 0; vh2 = 0; fh1 = 0;
      m_valid = 1'b1;
    end else begin
      // Sync flags take effect one clock after they are sampled.
      m_hr = hh1 && !hh2;
      m_fs = !vh1 && vh2;
      m_hs = key_valid && !m_pfull;
      m_cv = 0;
      m_fs_out = 0;
      if (m_state == 0) begin
        if (m_hs) begin
          m_pend = key_in; m_pfull = 1; m_state = 1;
        end
      end else if (m_fs) begin
        if (m_hs) m_key = key_in;
        else if (m_pfull) m_key = m_pend;
        else m_key = m_active;
        m_active = m_key;
        m_seed = fh1 ? {m_key[7:0], m_key[15:8]} : m_key;
        if (m_seed == 0) m_seed = 16'h0001;
        m_lfsr = m_seed;
        m_pfull = 0; m_fs_out = 1; m_idx = 0; m_state = 2;
      end else begin
        if (m_hs) begin
          m_pend = key_in; m_pfull = 1;
        end
        if (m_state == 2 && m_hr && !vh1) begin
          m_lfsr = m_step(m_lfsr);
          m_cut = enable ? m_lfsr[7:0] : 8'h00;
          m_cv = 1;
          if (m_idx < 1023) m_idx = m_idx + 1;
        end
      end
      m_run = (m_state == 2);
      hh2 = hh1; hh1 = H;
      vh2 = vh1; vh1 = V;
      fh1 = F;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("cut_position", 32'(cut_position), 32'(m_cut));
      chk("cut_valid",    32'(cut_valid),    32'(m_cv));
      chk("line_index",   32'(line_index),   32'(m_idx));
      chk("field_start",  32'(field_start),  32'(m_fs_out));
      chk("running",      32'(running),      32'(m_run));
      chk("key_ready",    32'(key_ready),    32'(!m_pfull));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [15:0] k);
    key_in = k; key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
  endtask

  task automatic field(input bit f);
    V = 1'b1; tick(3);
    V = 1'b0; F = f; tick(4);
  endtask

  task automatic line();
    H = 1'b1; tick(3);
    H = 1'b0; tick(3);
  endtask

  initial begin
    reset = 1'b1; H = 0; V = 0; F = 0; enable = 1'b1; key_valid = 0; key_in = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_key_ready", 32'(key_ready), 32'd1);
    chk("rst_running",   32'(running),   32'd0);
    chk("rst_cut",       32'(cut_position), 32'd0);
    $display("txn reset: key_ready=%0d running=%0d", key_ready, running);

    // Key in IDLE, even field, two lines.
    offer(16'hACE1);
    chk("idle_key_taken", 32'(key_ready), 32'd0);
    field(1'b0);
    chk("field0_running", 32'(running), 32'd1);
    line();
    chk("f0_line1_cut", 32'(cut_position), 32'h70);
    chk("f0_line1_idx", 32'(line_index), 32'd1);
    $display("txn line: cut=%02h idx=%0d", cut_position, line_index);
    line();
    chk("f0_line2_cut", 32'(cut_position), 32'h38);
    chk("f0_line2_idx", 32'(line_index), 32'd2);
    $display("txn line: cut=%02h idx=%0d", cut_position, line_index);

    // Odd field reuses the key byte-swapped.
    field(1'b1);
    line();
    chk("f1_line1_cut", 32'(cut_position), 32'hD6);
    $display("txn odd field line: cut=%02h", cut_position);

    // Zero key accepted in RUN; a second key stalls until the field start.
    offer(16'h0000);
    chk("run_key_ready_low", 32'(key_ready), 32'd0);
    key_in = 16'h1234; key_valid = 1'b1;
    tick(4);
    key_valid = 1'b0;
    chk("stalled_key_ready", 32'(key_ready), 32'd0);
    field(1'b0);
    chk("after_fs_ready", 32'(key_ready), 32'd1);
    line();
    chk("zero_key_cut", 32'(cut_position), 32'h00);
    $display("txn zero key line: cut=%02h", cut_position);

    // Key handshaking on the field-start cycle seeds that field directly.
    V = 1'b1; tick(3);
    V = 1'b0; F = 1'b0; tick(1);
    key_in = 16'h5A5A; key_valid = 1'b1; tick(1);
    key_valid = 1'b0; tick(3);
    chk("bypass_ready", 32'(key_ready), 32'd1);
    line();
    chk("bypass_cut", 32'(cut_position), 32'h2D);
    $display("txn bypass key line: cut=%02h", cut_position);

    // enable low for three lines keeps the LFSR stepping.
    offer(16'hACE1);
    field(1'b0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      line();
      chk("disabled_cut", 32'(cut_position), 32'h00);
      $display("txn disabled line %0d: cut=%02h", i + 1, cut_position);
    end
    enable = 1'b1;
    line();
    chk("reenabled_cut", 32'(cut_position), 32'h4E);
    chk("reenabled_idx", 32'(line_index), 32'd4);
    $display("txn enabled line 4: cut=%02h idx=%0d", cut_position, line_index);

    // h_rise during vertical blanking is ignored; h_rise on field start loses.
    V = 1'b1; tick(1);
    line();
    chk("vblank_idx", 32'(line_index), 32'd4);
    chk("vblank_cut", 32'(cut_position), 32'h4E);
    V = 1'b0; F = 1'b0; H = 1'b1; tick(3);
    H = 1'b0; tick(3);
    chk("coincide_idx", 32'(line_index), 32'd0);
    line();
    chk("coincide_next_cut", 32'(cut_position), 32'h70);
    $display("txn after coincident fs: cut=%02h idx=%0d", cut_position, line_index);

    // Reset with a pending key: back to IDLE, nothing runs until key and field.
    offer(16'h1111);
    chk("pending_before_rst", 32'(key_ready), 32'd0);
    reset = 1'b1; tick(1);
    reset = 1'b0;
    chk("midrst_key_ready", 32'(key_ready), 32'd1);
    chk("midrst_running",   32'(running), 32'd0);
    chk("midrst_cut",       32'(cut_position), 32'd0);
    chk("midrst_idx",       32'(line_index), 32'd0);
    line();
    chk("idle_line_cut", 32'(cut_position), 32'd0);
    $display("txn mid reset: key_ready=%0d running=%0d", key_ready, running);
    offer(16'hACE1);
    field(1'b0);
    line();
    chk("recover_cut", 32'(cut_position), 32'h70);
    $display("txn recovery line: cut=%02h", cut_position);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
